// File: rtl/fp16_pkg.sv
// Shared binary16 constants and the S1->S2 bundle for the FP16
// multiply pack stage.
package fp16_pkg;

    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int SIG_W    = 14;
    localparam int EXP_BIAS = 15;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP16_W-1:0] FP16_INF  = 16'h7C00;

    // S1 -> S2 bundle.
    // exp is the biased exponent; 0 marks a denormalized significand.
    // sig is P[12:1] after normalization: hidden, 10 frac bits, guard.
    // sticky already folds in P[0] and the upstream round_loss.
    typedef struct packed {
        logic                valid;
        logic                sign;
        logic signed [7:0]   exp;
        logic [11:0]         sig;
        logic                sticky;
        logic                special;
        logic [FP16_W-1:0]   special_val;
    } s1_s2_t;

endpackage

// File: rtl/lzc_14b.sv
// Leading-zero counter over 14 bits.
// Ports: din (14b) in, count (4b) out; count = 14 when din == 0.
module lzc_14b (
    input  logic [13:0] din,
    output logic [3:0]  count
);

    logic found;

    always_comb begin
        count = 4'd0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found) begin
                if (din[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mul_fp16_pack.sv
// FP16 multiply pack: exponent, normalize, RNE round, specials, pack.
// Ports: clk, rst (sync, active high); in_valid/in_ready handshake with
// sign1/2, exp1/2, product, carry_out, round_loss, in_nan operand data;
// out_valid/out_ready handshake with the packed binary16 result.
module mul_fp16_pack
    import fp16_pkg::*;
#(
    parameter int EXP_BIAS      = fp16_pkg::EXP_BIAS,
    parameter bit FLUSH_SUBNORM = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign1,
    input  logic              sign2,
    input  logic [EXP_W-1:0]  exp1,
    input  logic [EXP_W-1:0]  exp2,
    input  logic [SIG_W-2:0]  product,
    input  logic              carry_out,
    input  logic              round_loss,
    input  logic              in_nan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] result
);

    s1_s2_t            s1_q, s1_d, s1_new;
    logic              out_valid_q, out_valid_d;
    logic [FP16_W-1:0] result_q, result_d;

    logic              s2_adv;

    logic [SIG_W-1:0]  p_raw, p_n;
    logic signed [7:0] e_n, rsh_w;
    logic [3:0]        lz, lsh, rsh;
    logic              st_n, was_sub, flush;
    logic              p_zero, inf_zero, any_inf, sgn;

    logic [7:0]        ez;
    logic [11:0]       m_n, m_r;
    logic              inc;
    logic [16:0]       mag;
    logic [FP16_W-1:0] packed_res;

    lzc_14b u_lzc (
        .din   (p_raw),
        .count (lz)
    );

    assign s2_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_q.valid || s2_adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // S1: exponent and normalization.
    always_comb begin
        p_raw   = {carry_out, product};
        p_n     = p_raw;
        e_n     = 8'({3'b000, exp1} + {3'b000, exp2}) - 8'(EXP_BIAS);
        st_n    = round_loss;
        lsh     = 4'd0;
        rsh     = 4'd0;
        rsh_w   = 8'sd0;
        was_sub = 1'b0;
        sgn     = sign1 ^ sign2;

        if (p_raw[13]) begin
            st_n = st_n | p_raw[0];
            p_n  = p_raw >> 1;
            e_n  = e_n + 8'sd1;
        end else if (!p_raw[12] && p_raw != '0) begin
            // Normalize up, but never below the minimum normal exponent.
            lsh = lz - 4'd1;
            if (e_n <= 8'sd1) begin
                lsh = 4'd0;
            end else if (e_n - 8'sd1 < $signed({4'b0000, lsh})) begin
                lsh = 4'(e_n - 8'sd1);
            end
            p_n = p_raw << lsh;
            e_n = e_n - $signed({4'b0000, lsh});
        end

        // Denormalize; bits pushed out feed the sticky.
        if (e_n <= 8'sd0) begin
            was_sub = 1'b1;
            rsh_w   = 8'sd1 - e_n;
            rsh     = (rsh_w > 8'sd14) ? 4'd14 : rsh_w[3:0];
            st_n    = st_n | (|(p_n & ~(14'h3FFF << rsh)));
            p_n     = p_n >> rsh;
            e_n     = 8'sd0;
        end

        st_n = st_n | p_n[0];

        flush    = FLUSH_SUBNORM && (was_sub || !p_n[12]);
        p_zero   = (p_raw == '0);
        inf_zero = ((exp1 == 5'd31) && (exp2 == 5'd0) && p_zero) ||
                   ((exp2 == 5'd31) && (exp1 == 5'd0) && p_zero);
        any_inf  = (exp1 == 5'd31) || (exp2 == 5'd31);

        s1_new             = '0;
        s1_new.valid       = in_valid;
        s1_new.sign        = sgn;
        s1_new.exp         = e_n;
        s1_new.sig         = p_n[12:1];
        s1_new.sticky      = st_n;
        s1_new.special     = 1'b1;
        if (in_nan || inf_zero) begin
            s1_new.special_val = FP16_QNAN;
        end else if (any_inf) begin
            s1_new.special_val = {sgn, FP16_INF[14:0]};
        end else if (p_zero || flush) begin
            s1_new.special_val = {sgn, 15'h0000};
        end else begin
            s1_new.special = 1'b0;
        end

        s1_d = s1_q;
        if (in_ready) begin
            s1_d = s1_new;
        end
    end

    // S2: round to nearest even and pack.
    always_comb begin
        // A zero exponent still scales like the minimum normal.
        ez  = (s1_q.exp < 8'sd1) ? 8'd1 : 8'(s1_q.exp);
        m_n = {1'b0, s1_q.sig[11:1]};
        inc = s1_q.sig[0] && (s1_q.sticky || s1_q.sig[1]);
        m_r = m_n + {11'd0, inc};
        // Adding the hidden bit on top of (ez-1) lets a mantissa carry
        // or a denormal rounding up ripple into the exponent field.
        mag = (({9'd0, ez} - 17'd1) << FRAC_W) + {5'd0, m_r};

        if (s1_q.special) begin
            packed_res = s1_q.special_val;
        end else if (mag >= 17'h07C00) begin
            packed_res = {s1_q.sign, FP16_INF[14:0]};
        end else begin
            packed_res = {s1_q.sign, mag[14:0]};
        end

        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (s2_adv) begin
            out_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                result_d = packed_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_fp16_pack.sv
// Self-checking bench for mul_fp16_pack: directed cases, handshake,
// reset flush and randomized beats against an arithmetic reference.
module tb_mul_fp16_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign1, sign2;
    logic [4:0]  exp1, exp2;
    logic [12:0] product;
    logic        carry_out;
    logic        round_loss;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s1;
        logic        s2;
        logic [4:0]  e1;
        logic [4:0]  e2;
        logic        cy;
        logic [12:0] prod;
        logic        rl;
        logic        nan;
    } beat_t;

    logic [15:0] exp_q[$];

    mul_fp16_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sign1      (sign1),
        .sign2      (sign2),
        .exp1       (exp1),
        .exp2       (exp2),
        .product    (product),
        .carry_out  (carry_out),
        .round_loss (round_loss),
        .in_nan     (in_nan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic s1, input logic s2,
                                 input int e1, input int e2,
                                 input logic cy, input logic [12:0] prod,
                                 input logic rl, input logic nan);
        beat_t b;
        b.s1 = s1; b.s2 = s2;
        b.e1 = 5'(e1); b.e2 = 5'(e2);
        b.cy = cy; b.prod = prod;
        b.rl = rl; b.nan = nan;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        sign1 = b.s1; sign2 = b.s2;
        exp1 = b.e1; exp2 = b.e2;
        carry_out = b.cy; product = b.prod;
        round_loss = b.rl; in_nan = b.nan;
    endtask

    // Value = P * 2^(e1+e2-30-12); round to the binary16 grid at
    // exponent q with round-to-nearest-even, round_loss as a tiny excess.
    function automatic logic [15:0] ref_mul(input beat_t b);
        int     p, e, m, q, sh, ef;
        longint k, d, r;
        logic   s;
        s = b.s1 ^ b.s2;
        p = int'({b.cy, b.prod});
        if (b.nan) return 16'h7E00;
        if (p == 0 && ((b.e1 == 31 && b.e2 == 0) ||
                       (b.e2 == 31 && b.e1 == 0)))
            return 16'h7E00;
        if (b.e1 == 31 || b.e2 == 31) return {s, 15'h7C00};
        if (p == 0) return {s, 15'h0000};
        e = int'(b.e1) + int'(b.e2) - 42;
        m = 0;
        for (int i = 0; i < 14; i++) if (p[i]) m = i;
        q  = ((m + e > -14) ? (m + e) : -14) - 10;
        sh = q - e;
        if (sh <= 0) begin
            k = longint'(p) << (-sh);
        end else begin
            d = 64'sd1 << sh;
            k = p / d;
            r = p % d;
            if (2 * r > d || (2 * r == d && (b.rl || k[0]))) k++;
        end
        if (k == 2048) begin
            k = 1024;
            q++;
        end
        if (k >= 1024) begin
            ef = q + 25;
            if (ef >= 31) return {s, 15'h7C00};
            return {s, 5'(ef), 10'(k - 1024)};
        end
        return {s, 5'b00000, 10'(k)};
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [13:0] t;
        b.s1 = 1'($urandom);
        b.s2 = 1'($urandom);
        b.e1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(7, 23));
        b.e2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(7, 23));
        t = 14'($urandom);
        if ($urandom_range(0, 7) == 0) t = t >> $urandom_range(2, 13);
        if ($urandom_range(0, 15) == 0) t = '0;
        {b.cy, b.prod} = t;
        b.rl  = 1'($urandom);
        b.nan = ($urandom_range(0, 31) == 0);
        return b;
    endfunction

    task automatic run_one(input string tag, input beat_t b,
                           input logic [15:0] want);
        int cyc;
        drive(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd2);
        chk(tag, {16'h0, result}, {16'h0, want});
        @(posedge clk); #1;
    endtask

    initial begin
        int    idx, got, seen, sent, cyc;
        logic  fin, fout;
        logic [15:0] r;
        beat_t cur;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 13'h0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", {31'h0, out_valid}, 32'd0);
        chk("rst_res", {16'h0, result}, 32'd0);
        chk("rst_ir", {31'h0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_one("one", mk(0, 0, 15, 15, 0, 13'h1000, 0, 0), 16'h3C00);
        run_one("p15", mk(0, 0, 15, 15, 1, 13'h0400, 0, 0), 16'h4080);
        run_one("p15n", mk(1, 0, 15, 15, 1, 13'h0400, 0, 0), 16'hC080);
        run_one("tie", mk(0, 0, 15, 15, 0, 13'h1002, 0, 0), 16'h3C00);
        run_one("tie_rl", mk(0, 0, 15, 15, 0, 13'h1002, 1, 0), 16'h3C01);
        run_one("ovf", mk(0, 0, 30, 30, 0, 13'h1000, 0, 0), 16'h7C00);
        run_one("unf", mk(0, 0, 8, 1, 0, 13'h1000, 0, 0), 16'h0008);
        run_one("sub_up", mk(0, 0, 8, 7, 0, 13'h1FFF, 0, 0), 16'h0400);
        run_one("nan", mk(0, 0, 15, 15, 0, 13'h1000, 0, 1), 16'h7E00);
        run_one("infz", mk(0, 0, 31, 0, 0, 13'h0000, 0, 0), 16'h7E00);
        run_one("inf", mk(0, 0, 31, 15, 0, 13'h1000, 0, 0), 16'h7C00);
        run_one("zero", mk(1, 0, 10, 10, 0, 13'h0000, 0, 0), 16'h8000);

        // Back-pressure: four beats with the consumer stalled.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(mk(0, 0, 15, 15 + idx, 0, 13'h1000, 0, 0));
            in_valid = (idx < 4);
            #1;
            fin = in_valid && in_ready;
            @(posedge clk); #1;
            if (fin) idx++;
        end
        chk("hs_acc", 32'(idx), 32'd2);
        chk("hs_in_ready", {31'h0, in_ready}, 32'd0);
        chk("hs_hold", {16'h0, result}, 32'h3C00);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            drive(mk(0, 0, 15, 15 + idx, 0, 13'h1000, 0, 0));
            in_valid = (idx < 4);
            #1;
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            r    = result;
            @(posedge clk); #1;
            if (fin) idx++;
            if (fout) begin
                chk("hs_order", {16'h0, r}, 32'h3C00 + 32'(got << 10));
                got++;
            end
        end
        in_valid = 1'b0;
        chk("hs_count", 32'(got), 32'd4);
        chk("hs_idle", {31'h0, out_valid}, 32'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        drive(mk(0, 0, 15, 15, 0, 13'h1000, 0, 0));
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ov", {31'h0, out_valid}, 32'd0);
        chk("rst_mid_ir", {31'h0, in_ready}, 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_drop", 32'(seen), 32'd0);

        // Randomized stream against the reference model.
        sent = 0;
        cyc  = 0;
        cur  = rand_beat();
        while ((sent < 400 || exp_q.size() > 0) && cyc < 6000) begin
            drive(cur);
            in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            r    = result;
            @(posedge clk); #1;
            cyc++;
            if (fin) begin
                exp_q.push_back(ref_mul(cur));
                sent++;
                cur = rand_beat();
            end
            if (fout) begin
                if (exp_q.size() == 0) chk("rnd_extra", {31'h0, fout}, 32'd0);
                else chk("rnd", {16'h0, r}, {16'h0, exp_q.pop_front()});
            end
        end
        in_valid = 1'b0;
        chk("rnd_sent", 32'(sent), 32'd400);
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
